// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operation sequencer: opcodes, FSM
// states, flag bit positions and the latched command payload.
package alu_seq_pkg;

  localparam int unsigned WIDTH     = 32;
  localparam int unsigned OPW       = 4;
  localparam int unsigned MUL_ITERS = WIDTH;
  localparam int unsigned CNT_W     = 6;
  localparam int unsigned FLAGS_W   = 4;

  localparam logic [OPW-1:0] OP_ADD = 4'd0;
  localparam logic [OPW-1:0] OP_SUB = 4'd1;
  localparam logic [OPW-1:0] OP_AND = 4'd2;
  localparam logic [OPW-1:0] OP_OR  = 4'd3;
  localparam logic [OPW-1:0] OP_XOR = 4'd4;
  localparam logic [OPW-1:0] OP_NOR = 4'd5;
  localparam logic [OPW-1:0] OP_NOT = 4'd6;
  localparam logic [OPW-1:0] OP_MUL = 4'd7;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef struct packed {
    logic [OPW-1:0]   op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
  } cmd_t;

  function automatic logic op_is_legal(input logic [OPW-1:0] op);
    return op <= OP_MUL;
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Command/response bundle between the issue logic (master) and the sequencer (slave).
interface alu_op_sequencer_if;
  import alu_seq_pkg::*;

  logic               cmd_valid;
  logic               cmd_ready;
  logic [OPW-1:0]     cmd_op;
  logic [WIDTH-1:0]   cmd_a;
  logic [WIDTH-1:0]   cmd_b;
  logic               cmd_cin;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [WIDTH-1:0]   rsp_result;
  logic [WIDTH-1:0]   rsp_hi;
  logic [FLAGS_W-1:0] rsp_flags;
  logic               rsp_err;
  logic               busy;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_cin, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_result, rsp_hi, rsp_flags, rsp_err, busy
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_cin, rsp_ready,
    output cmd_ready, rsp_valid, rsp_result, rsp_hi, rsp_flags, rsp_err, busy
  );

endinterface

// File: rtl/alu_datapath_32.sv
// Combinational ALU: arithmetic and logic units behind an opcode mux.
// carry is carry-out for ADD, borrow-out for SUB, 0 otherwise.
module alu_datapath_32
  import alu_seq_pkg::*;
(
  input  logic [OPW-1:0]   op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             ovf
);

  logic [WIDTH-1:0] add_sum;
  logic             add_cout;
  logic [WIDTH-1:0] sub_diff;
  logic             sub_bout;
  logic [WIDTH-1:0] and_y, or_y, xor_y, nor_y, not_y;

  full_adder_32bit u_add (
    .a    (a),
    .b    (b),
    .cin  (cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  full_subtractor_32bit u_sub (
    .a    (a),
    .b    (b),
    .bin  (cin),
    .diff (sub_diff),
    .bout (sub_bout)
  );

  logic_gates_32bit u_logic (
    .a     (a),
    .b     (b),
    .and_y (and_y),
    .or_y  (or_y),
    .xor_y (xor_y),
    .nor_y (nor_y),
    .not_y (not_y)
  );

  always_comb begin
    result = '0;
    carry  = 1'b0;
    ovf    = 1'b0;
    case (op)
      OP_ADD: begin
        result = add_sum;
        carry  = add_cout;
        ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (add_sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        result = sub_diff;
        carry  = sub_bout;
        ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (sub_diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  result = and_y;
      OP_OR:   result = or_y;
      OP_XOR:  result = xor_y;
      OP_NOR:  result = nor_y;
      OP_NOT:  result = not_y;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/full_adder_32bit.sv
// 32-bit adder with carry-in and carry-out.
module full_adder_32bit
  import alu_seq_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] total;

  assign total = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin);
  assign sum   = total[WIDTH-1:0];
  assign cout  = total[WIDTH];

endmodule

// File: rtl/full_subtractor_32bit.sv
// 32-bit subtractor with borrow-in and borrow-out.
module full_subtractor_32bit
  import alu_seq_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  logic [WIDTH:0] total;

  // A 33-bit wrap leaves bit 32 set exactly when A < B + bin.
  assign total = {1'b0, a} - {1'b0, b} - (WIDTH+1)'(bin);
  assign diff  = total[WIDTH-1:0];
  assign bout  = total[WIDTH];

endmodule

// File: rtl/logic_gates_32bit.sv
// Bitwise AND/OR/XOR/NOR and NOT(A) over 32-bit operands.
module logic_gates_32bit
  import alu_seq_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] and_y,
  output logic [WIDTH-1:0] or_y,
  output logic [WIDTH-1:0] xor_y,
  output logic [WIDTH-1:0] nor_y,
  output logic [WIDTH-1:0] not_y
);

  assign and_y = a & b;
  assign or_y  = a | b;
  assign xor_y = a ^ b;
  assign nor_y = ~(a | b);
  assign not_y = ~a;

endmodule

// File: rtl/alu_op_sequencer.sv
// Single-command ALU sequencer: one-cycle ops via EXEC, 32-cycle shift-add
// multiply via MUL reusing the datapath adder, response held in DONE.
module alu_op_sequencer
  import alu_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  alu_op_sequencer_if.slave bus
);

  localparam int unsigned PW = 2 * WIDTH;

  state_e             state_q, state_d;
  cmd_t               cmd_q, cmd_d;
  logic [PW-1:0]      prod_q, prod_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [FLAGS_W-1:0] flags_q, flags_d;
  logic               err_q, err_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               busy_q, busy_d;

  logic [OPW-1:0]     dp_op;
  logic [WIDTH-1:0]   dp_a, dp_b, dp_result;
  logic               dp_cin, dp_carry, dp_ovf;
  logic               mul_last;

  alu_datapath_32 u_dp (
    .op     (dp_op),
    .a      (dp_a),
    .b      (dp_b),
    .cin    (dp_cin),
    .result (dp_result),
    .carry  (dp_carry),
    .ovf    (dp_ovf)
  );

  assign mul_last = (cnt_q == CNT_W'(MUL_ITERS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.cmd_valid) state_d = (bus.cmd_op == OP_MUL) ? MUL : EXEC;
      EXEC:    state_d = DONE;
      MUL:     if (mul_last) state_d = DONE;
      DONE:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_d   = cmd_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    hi_d    = hi_q;
    flags_d = flags_q;
    err_d   = err_q;
    dp_op   = cmd_q.op;
    dp_a    = cmd_q.a;
    dp_b    = cmd_q.b;
    dp_cin  = cmd_q.cin;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          cmd_d.op  = bus.cmd_op;
          cmd_d.a   = bus.cmd_a;
          cmd_d.b   = bus.cmd_b;
          cmd_d.cin = bus.cmd_cin;
          prod_d    = {{WIDTH{1'b0}}, bus.cmd_b};
          cnt_d     = '0;
        end
      end
      EXEC: begin
        hi_d    = '0;
        flags_d = '0;
        if (op_is_legal(cmd_q.op)) begin
          res_d           = dp_result;
          err_d           = 1'b0;
          flags_d[FLAG_N] = dp_result[WIDTH-1];
          flags_d[FLAG_Z] = (dp_result == '0);
          flags_d[FLAG_C] = dp_carry;
          flags_d[FLAG_V] = dp_ovf;
        end else begin
          res_d = '0;
          err_d = 1'b1;
        end
      end
      MUL: begin
        // Upper half plus multiplicand through the shared adder, carry kept as bit 63.
        dp_op  = OP_ADD;
        dp_a   = prod_q[PW-1:WIDTH];
        dp_b   = cmd_q.a;
        dp_cin = 1'b0;
        if (prod_q[0]) prod_d = {dp_carry, dp_result, prod_q[WIDTH-1:1]};
        else           prod_d = {1'b0, prod_q[PW-1:1]};
        if (mul_last) begin
          cnt_d           = '0;
          res_d           = prod_d[WIDTH-1:0];
          hi_d            = prod_d[PW-1:WIDTH];
          err_d           = 1'b0;
          flags_d         = '0;
          flags_d[FLAG_N] = prod_d[PW-1];
          flags_d[FLAG_Z] = (prod_d == '0);
          flags_d[FLAG_C] = (prod_d[PW-1:WIDTH] != '0);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
    rsp_valid_d = (state_d == DONE);
    cmd_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_q       <= '0;
      prod_q      <= '0;
      cnt_q       <= '0;
      res_q       <= '0;
      hi_q        <= '0;
      flags_q     <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      cmd_q       <= cmd_d;
      prod_q      <= prod_d;
      cnt_q       <= cnt_d;
      res_q       <= res_d;
      hi_q        <= hi_d;
      flags_q     <= flags_d;
      err_q       <= err_d;
      rsp_valid_q <= rsp_valid_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.cmd_ready  = cmd_ready_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = res_q;
  assign bus.rsp_hi     = hi_q;
  assign bus.rsp_flags  = flags_q;
  assign bus.rsp_err    = err_q;
  assign bus.busy       = busy_q;

endmodule
